// File: rtl/otter_arb_pkg.sv
// Shared types for the OTTER data-memory port arbiter: FSM states, requester
// identifiers and memory access size encodings.
package otter_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DMA_BURST = 2'd1,
    CPU_SLOT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DMA = 1'b1
  } req_id_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/otter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over
// increment.
module otter_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/otter_dmem_arbiter.sv
// Arbiter sharing OTTER memory port 2 between the CPU and a DMA/debug master.
// Define DMEM_ARB_PERF_EN to enable the CPU stall counter on PERF_STALL_CNT.
module otter_dmem_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CPU_REQ,
  input  logic [31:0] CPU_ADDR,
  input  logic [31:0] CPU_WDATA,
  input  logic        CPU_WE,
  input  logic [1:0]  CPU_SIZE,
  input  logic        CPU_SIGN,
  output logic        CPU_GNT,
  output logic [31:0] CPU_RDATA,
  output logic        CPU_RVALID,
  input  logic        DMA_REQ,
  input  logic [31:0] DMA_ADDR,
  input  logic [31:0] DMA_WDATA,
  input  logic        DMA_WE,
  input  logic [1:0]  DMA_SIZE,
  input  logic        DMA_SIGN,
  input  logic        DMA_LAST,
  output logic        DMA_GNT,
  output logic [31:0] DMA_RDATA,
  output logic        DMA_RVALID,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic        MEM_WRITE2,
  output logic        MEM_READ2,
  output logic [1:0]  MEM_SIZE,
  output logic        MEM_SIGN,
  input  logic [31:0] MEM_DOUT2,
  output logic [31:0] PERF_STALL_CNT
);

  import otter_arb_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] eff_cnt;
  logic             gnt_cpu;
  logic             gnt_dma;
  logic             rd_pending;
  req_id_t          rd_owner;
  logic             rsp_live;

  // Stage p0: arbitration and burst accounting (combinational grant)
  always_comb begin
    gnt_cpu   = 1'b0;
    gnt_dma   = 1'b0;
    state_nxt = state;
    cnt_nxt   = beat_cnt;
    // A CPU_SLOT cycle without a CPU request behaves as a fresh burst position.
    eff_cnt   = (state == CPU_SLOT) ? '0 : beat_cnt;
    if (!RST) begin
      case (state)
        IDLE: begin
          if (CPU_REQ) begin
            gnt_cpu = 1'b1;
          end else if (DMA_REQ) begin
            gnt_dma   = 1'b1;
            state_nxt = DMA_LAST ? IDLE : DMA_BURST;
            cnt_nxt   = DMA_LAST ? '0 : CNT_W'(1);
          end
        end
        DMA_BURST, CPU_SLOT: begin
          if ((state == CPU_SLOT) && CPU_REQ) begin
            gnt_cpu   = 1'b1;
            state_nxt = DMA_BURST;
            cnt_nxt   = '0;
          end else begin
            state_nxt = DMA_BURST;
            cnt_nxt   = eff_cnt;
            if (CPU_REQ && (eff_cnt == CNT_MAX)) begin
              gnt_cpu   = 1'b1;
              state_nxt = CPU_SLOT;
              cnt_nxt   = '0;
            end else if (DMA_REQ) begin
              gnt_dma = 1'b1;
              if (DMA_LAST) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
              end else begin
                cnt_nxt = (eff_cnt == CNT_MAX) ? CNT_MAX : eff_cnt + CNT_W'(1);
              end
            end else if (CPU_REQ) begin
              gnt_cpu = 1'b1;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= cnt_nxt;
    end
  end

  assign CPU_GNT = gnt_cpu;
  assign DMA_GNT = gnt_dma;

  always_comb begin
    MEM_ADDR2  = '0;
    MEM_DIN2   = '0;
    MEM_WRITE2 = 1'b0;
    MEM_READ2  = 1'b0;
    MEM_SIZE   = '0;
    MEM_SIGN   = 1'b0;
    if (gnt_cpu) begin
      MEM_ADDR2  = CPU_ADDR;
      MEM_DIN2   = CPU_WDATA;
      MEM_WRITE2 = CPU_WE;
      MEM_READ2  = ~CPU_WE;
      MEM_SIZE   = CPU_SIZE;
      MEM_SIGN   = CPU_SIGN;
    end else if (gnt_dma) begin
      MEM_ADDR2  = DMA_ADDR;
      MEM_DIN2   = DMA_WDATA;
      MEM_WRITE2 = DMA_WE;
      MEM_READ2  = ~DMA_WE;
      MEM_SIZE   = DMA_SIZE;
      MEM_SIGN   = DMA_SIGN;
    end
  end

  // Stage p1: read-response tag, one cycle after the granted read
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_pending <= 1'b0;
    end else begin
      rd_pending <= MEM_READ2;
    end
  end

  always_ff @(posedge CLK) begin
    if (MEM_READ2) begin
      rd_owner <= gnt_dma ? REQ_DMA : REQ_CPU;
    end
  end

  // A response still in flight when reset arrives is dropped, not delivered.
  assign rsp_live   = rd_pending & ~RST;
  assign CPU_RVALID = rsp_live & (rd_owner == REQ_CPU);
  assign DMA_RVALID = rsp_live & (rd_owner == REQ_DMA);
  assign CPU_RDATA  = CPU_RVALID ? MEM_DOUT2 : '0;
  assign DMA_RDATA  = DMA_RVALID ? MEM_DOUT2 : '0;

`ifdef DMEM_ARB_PERF_EN
  logic cpu_stall;
  assign cpu_stall = CPU_REQ & ~gnt_cpu;

  otter_sat_counter #(
    .WIDTH (32)
  ) u_stall_cnt (
    .clk   (CLK),
    .inc   (cpu_stall),
    .clr   (RST),
    .count (PERF_STALL_CNT)
  );
`else
  assign PERF_STALL_CNT = '0;
`endif

endmodule

// File: tb/tb_otter_dmem_arbiter.sv
// Bench for otter_dmem_arbiter: directed vectors plus randomized traffic
// compared against a burst-accounting reference model.
module tb_otter_dmem_arbiter;

  localparam int MAX_BURST = 4;
`ifdef DMEM_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        CLK;
  logic        RST;
  logic        CPU_REQ;
  logic [31:0] CPU_ADDR;
  logic [31:0] CPU_WDATA;
  logic        CPU_WE;
  logic [1:0]  CPU_SIZE;
  logic        CPU_SIGN;
  logic        CPU_GNT;
  logic [31:0] CPU_RDATA;
  logic        CPU_RVALID;
  logic        DMA_REQ;
  logic [31:0] DMA_ADDR;
  logic [31:0] DMA_WDATA;
  logic        DMA_WE;
  logic [1:0]  DMA_SIZE;
  logic        DMA_SIGN;
  logic        DMA_LAST;
  logic        DMA_GNT;
  logic [31:0] DMA_RDATA;
  logic        DMA_RVALID;
  logic [31:0] MEM_ADDR2;
  logic [31:0] MEM_DIN2;
  logic        MEM_WRITE2;
  logic        MEM_READ2;
  logic [1:0]  MEM_SIZE;
  logic        MEM_SIGN;
  logic [31:0] MEM_DOUT2;
  logic [31:0] PERF_STALL_CNT;

  otter_dmem_arbiter #(.MAX_BURST(MAX_BURST)) dut (
    .CLK(CLK), .RST(RST),
    .CPU_REQ(CPU_REQ), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA), .CPU_WE(CPU_WE),
    .CPU_SIZE(CPU_SIZE), .CPU_SIGN(CPU_SIGN), .CPU_GNT(CPU_GNT),
    .CPU_RDATA(CPU_RDATA), .CPU_RVALID(CPU_RVALID),
    .DMA_REQ(DMA_REQ), .DMA_ADDR(DMA_ADDR), .DMA_WDATA(DMA_WDATA), .DMA_WE(DMA_WE),
    .DMA_SIZE(DMA_SIZE), .DMA_SIGN(DMA_SIGN), .DMA_LAST(DMA_LAST), .DMA_GNT(DMA_GNT),
    .DMA_RDATA(DMA_RDATA), .DMA_RVALID(DMA_RVALID),
    .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2), .MEM_WRITE2(MEM_WRITE2),
    .MEM_READ2(MEM_READ2), .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN),
    .MEM_DOUT2(MEM_DOUT2), .PERF_STALL_CNT(PERF_STALL_CNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: whether a DMA burst is open, how many DMA beats it has
  // taken since the CPU was last forcibly served, and whether the CPU is owed
  // a priority slot right now.
  bit          m_open, m_slot;
  int          m_streak;
  bit          m_rd_v, m_rd_dma;
  logic [31:0] m_stall;
  bit          e_cpu, e_dma;
  bit          last_cpu_gnt, last_dma_gnt;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_open = 0; m_slot = 0; m_streak = 0;
    m_rd_v = 0; m_rd_dma = 0; m_stall = '0;
  endtask

  task automatic sample();
    bit prio;
    logic [95:0] bus;
    bit cpu_rv, dma_rv;
    @(negedge CLK);
    e_cpu = 0;
    e_dma = 0;
    if (!RST) begin
      prio  = !m_open || m_slot || (m_streak >= MAX_BURST);
      e_cpu = CPU_REQ && (prio || !DMA_REQ);
      e_dma = DMA_REQ && !e_cpu;
    end
    bus = '0;
    if (e_cpu) bus = {27'd0, CPU_ADDR, CPU_WDATA, CPU_WE, !CPU_WE, CPU_SIZE, CPU_SIGN};
    if (e_dma) bus = {27'd0, DMA_ADDR, DMA_WDATA, DMA_WE, !DMA_WE, DMA_SIZE, DMA_SIGN};
    cpu_rv = m_rd_v && !m_rd_dma && !RST;
    dma_rv = m_rd_v && m_rd_dma && !RST;
    chk("grants", {94'd0, CPU_GNT, DMA_GNT}, {94'd0, e_cpu, e_dma});
    chk("mem_bus", {27'd0, MEM_ADDR2, MEM_DIN2, MEM_WRITE2, MEM_READ2, MEM_SIZE, MEM_SIGN}, bus);
    chk("cpu_rsp", {63'd0, CPU_RVALID, CPU_RDATA}, {63'd0, cpu_rv, cpu_rv ? MEM_DOUT2 : 32'd0});
    chk("dma_rsp", {63'd0, DMA_RVALID, DMA_RDATA}, {63'd0, dma_rv, dma_rv ? MEM_DOUT2 : 32'd0});
    chk("perf", {64'd0, PERF_STALL_CNT}, {64'd0, PERF ? m_stall : 32'd0});
  endtask

  task automatic advance();
    if (RST) begin
      model_reset();
    end else begin
      m_rd_v   = (e_cpu && !CPU_WE) || (e_dma && !DMA_WE);
      m_rd_dma = e_dma;
      if (CPU_REQ && !e_cpu && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 1;
      if (e_dma) begin
        m_slot = 0;
        if (DMA_LAST) begin
          m_open = 0; m_streak = 0;
        end else begin
          m_open = 1;
          m_streak = (m_streak + 1 > MAX_BURST) ? MAX_BURST : m_streak + 1;
        end
      end else if (e_cpu) begin
        if (m_slot) begin
          m_slot = 0; m_streak = 0;
        end else if (m_open && (m_streak >= MAX_BURST)) begin
          m_slot = 1; m_streak = 0;
        end
      end else if (m_slot) begin
        m_slot = 0; m_streak = 0;
      end
    end
    last_cpu_gnt = e_cpu;
    last_dma_gnt = e_dma;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    RST = 0; CPU_REQ = 0; DMA_REQ = 0; DMA_LAST = 0;
    CPU_WE = 0; DMA_WE = 0; CPU_SIZE = 2'd2; DMA_SIZE = 2'd2;
    CPU_SIGN = 0; DMA_SIGN = 0; CPU_ADDR = '0; DMA_ADDR = '0;
    CPU_WDATA = '0; DMA_WDATA = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1;
    sample();
    advance();
    RST = 0;
  endtask

  typedef struct {
    bit          cpu_req;
    bit          dma_req;
    bit          dma_last;
    logic [31:0] dma_addr;
    bit          x_cpu;
    bit          x_dma;
  } vec_t;

  vec_t tbl[11];

  initial begin
    // 8-beat DMA write burst with the CPU asking from beat 2 onward
    tbl[0]  = '{0, 1, 0, 32'h200, 0, 1};
    tbl[1]  = '{1, 1, 0, 32'h204, 0, 1};
    tbl[2]  = '{1, 1, 0, 32'h208, 0, 1};
    tbl[3]  = '{1, 1, 0, 32'h20C, 0, 1};
    tbl[4]  = '{1, 1, 0, 32'h210, 1, 0};
    tbl[5]  = '{0, 1, 0, 32'h210, 0, 1};
    tbl[6]  = '{0, 1, 0, 32'h214, 0, 1};
    tbl[7]  = '{0, 1, 0, 32'h218, 0, 1};
    tbl[8]  = '{0, 1, 1, 32'h21C, 0, 1};
    tbl[9]  = '{0, 0, 0, 32'h0,   0, 0};
    tbl[10] = '{1, 1, 0, 32'h220, 1, 0};

    model_reset();
    last_cpu_gnt = 0;
    last_dma_gnt = 0;
    MEM_DOUT2 = '0;
    do_reset();

    // Reset state, then simultaneous requests in IDLE
    idle_inputs();
    RST = 1;
    CPU_REQ = 1;
    sample();
    chk("rst_gnt", {94'd0, CPU_GNT, DMA_GNT}, 96'd0);
    chk("rst_rvalid", {94'd0, CPU_RVALID, DMA_RVALID}, 96'd0);
    chk("rst_perf", {64'd0, PERF_STALL_CNT}, 96'd0);
    advance();
    idle_inputs();
    CPU_REQ = 1; CPU_ADDR = 32'h100;
    DMA_REQ = 1; DMA_ADDR = 32'h500;
    sample();
    chk("tie_gnt", {94'd0, CPU_GNT, DMA_GNT}, 96'd2);
    chk("tie_read", {95'd0, MEM_READ2}, 96'd1);
    chk("tie_addr", {64'd0, MEM_ADDR2}, 96'h100);
    advance();
    idle_inputs();
    MEM_DOUT2 = 32'hDEAD_BEEF;
    sample();
    chk("tie_rsp", {63'd0, CPU_RVALID, CPU_RDATA}, {63'd0, 1'b1, 32'hDEAD_BEEF});
    advance();

    // Alternating reads CPU, DMA, CPU
    CPU_REQ = 1; CPU_ADDR = 32'h10; MEM_DOUT2 = 32'h1111_0000;
    sample(); advance();
    CPU_REQ = 0; DMA_REQ = 1; DMA_LAST = 1; DMA_ADDR = 32'h20; MEM_DOUT2 = 32'h1111_0001;
    sample();
    chk("alt1_cpu", {63'd0, CPU_RVALID, CPU_RDATA}, {63'd0, 1'b1, 32'h1111_0001});
    chk("alt1_dma", {95'd0, DMA_RVALID}, 96'd0);
    advance();
    DMA_REQ = 0; DMA_LAST = 0; CPU_REQ = 1; CPU_ADDR = 32'h30; MEM_DOUT2 = 32'h1111_0002;
    sample();
    chk("alt2_dma", {63'd0, DMA_RVALID, DMA_RDATA}, {63'd0, 1'b1, 32'h1111_0002});
    chk("alt2_cpu", {95'd0, CPU_RVALID}, 96'd0);
    advance();
    CPU_REQ = 0; MEM_DOUT2 = 32'h1111_0003;
    sample();
    chk("alt3_cpu", {63'd0, CPU_RVALID, CPU_RDATA}, {63'd0, 1'b1, 32'h1111_0003});
    advance();

    // Byte store produces a write and no response
    CPU_REQ = 1; CPU_WE = 1; CPU_SIZE = 2'd0; CPU_ADDR = 32'h103; CPU_WDATA = 32'h0000_00AB;
    sample();
    chk("st_strobes", {94'd0, MEM_WRITE2, MEM_READ2}, 96'd2);
    chk("st_size", {94'd0, MEM_SIZE}, 96'd0);
    chk("st_din", {64'd0, MEM_DIN2}, 96'hAB);
    advance();
    idle_inputs();
    sample();
    chk("st_norsp", {94'd0, CPU_RVALID, DMA_RVALID}, 96'd0);
    advance();

    // Reset the cycle after a granted DMA read
    DMA_REQ = 1; DMA_ADDR = 32'h600;
    sample(); advance();
    RST = 1; CPU_REQ = 1; MEM_DOUT2 = 32'h5555_AAAA;
    sample();
    chk("rstrd_gnt", {94'd0, CPU_GNT, DMA_GNT}, 96'd0);
    chk("rstrd_rv", {95'd0, DMA_RVALID}, 96'd0);
    advance();
    RST = 0;
    sample();
    chk("rstrd_idle", {94'd0, CPU_GNT, DMA_GNT}, 96'd2);
    chk("rstrd_rv2", {95'd0, DMA_RVALID}, 96'd0);
    advance();

    // Bounded burst table
    do_reset();
    idle_inputs();
    CPU_ADDR = 32'h300; DMA_WE = 1;
    for (int i = 0; i < 11; i++) begin
      CPU_REQ = tbl[i].cpu_req;
      DMA_REQ = tbl[i].dma_req;
      DMA_LAST = tbl[i].dma_last;
      DMA_ADDR = tbl[i].dma_addr;
      DMA_WDATA = tbl[i].dma_addr ^ 32'hA5A5_0000;
      sample();
      chk($sformatf("burst%0d_gnt", i), {94'd0, CPU_GNT, DMA_GNT}, {94'd0, tbl[i].x_cpu, tbl[i].x_dma});
      if (tbl[i].x_dma) chk($sformatf("burst%0d_addr", i), {64'd0, MEM_ADDR2}, {64'd0, tbl[i].dma_addr});
      advance();
    end
    idle_inputs();
    sample();
    chk("burst_stall", {64'd0, PERF_STALL_CNT}, PERF ? 96'd3 : 96'd0);
    advance();

    // Randomized traffic obeying the hold-until-granted rule
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      RST = ($urandom_range(0, 199) == 0);
      MEM_DOUT2 = $urandom;
      if (!(CPU_REQ && !last_cpu_gnt)) begin
        CPU_REQ = ($urandom_range(0, 99) < 50);
        CPU_ADDR = $urandom; CPU_WDATA = $urandom;
        CPU_WE = 1'($urandom_range(0, 1));
        CPU_SIZE = 2'($urandom_range(0, 2));
        CPU_SIGN = 1'($urandom_range(0, 1));
      end
      if (!(DMA_REQ && !last_dma_gnt)) begin
        DMA_REQ = ($urandom_range(0, 99) < 70);
        DMA_ADDR = $urandom; DMA_WDATA = $urandom;
        DMA_WE = 1'($urandom_range(0, 1));
        DMA_SIZE = 2'($urandom_range(0, 2));
        DMA_SIGN = 1'($urandom_range(0, 1));
        DMA_LAST = ($urandom_range(0, 5) == 0);
      end
      sample();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
